bus_arbiter_2m: RTL and testbench
=================================

// Module: bus_arbiter_2m
// PURPOSE
//   Two-master arbiter for the shared serial system bus. Grants bus tenure to one
//   requesting master and drives the select of the master-side mux2 instances
//   (addr/wdata/ctrl steering). Sits between the master ports and the bus
//   datapath muxes. Enforces a turnaround gap and a tenure timeout.
// PARAMETERS
//   RR_EN       1    1 = round-robin on contention; 0 = fixed priority, m0 wins
//   TIMEOUT     255  max tenure in cycles (1..255); 0 disables timeout
//   GAP_CYCLES  1    idle turnaround cycles after each release (0..7)
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   rst        in   1  synchronous reset, active-high
//   m0_req     in   1  master 0 requests bus; held for whole transaction
//   m1_req     in   1  master 1 requests bus; held for whole transaction
//   bus_done   in   1  1-cycle pulse from bus: current transaction complete
//   m0_grant   out  1  master 0 owns bus
//   m1_grant   out  1  master 1 owns bus
//   msel       out  1  mux2 select: 0 = m0 path, 1 = m1 path
//   bus_busy   out  1  high while either grant is high
//   timeout    out  1  1-cycle pulse: tenure forcibly ended by timeout
// BEHAVIOUR
//   - Reset: state IDLE; m0_grant=0, m1_grant=0, msel=0, bus_busy=0, timeout=0;
//     last_owner=1 (so first contention goes to m0); tenure/gap counters=0.
//   - All outputs registered. Grants mutually exclusive at all times.
//   - States: IDLE, GNT0, GNT1, GAP.
//   - IDLE: req sampled at edge N -> grant high from cycle N+1 (1-cycle latency).
//     Single req -> that master. Both req: RR_EN=1 -> master != last_owner;
//     RR_EN=0 -> m0. On entering GNTx: msel=x, last_owner=x, tenure cnt=0.
//   - msel changes only on IDLE->GNTx transition; holds in GAP/IDLE (no change
//     while any grant high).
//   - GNTx: tenure cnt increments each cycle. Release when any of:
//     bus_done=1, mx_req=0, or (TIMEOUT!=0 and cnt==TIMEOUT-1). Grant low the
//     cycle after release condition; next state GAP (GAP_CYCLES>0) else IDLE.
//   - Tenure length on timeout = exactly TIMEOUT cycles of grant high.
//   - timeout pulses 1 cycle, coincident with grant falling, only if release
//     cause is timeout alone; bus_done or req drop in same cycle -> no pulse.
//   - GAP: grants low for exactly GAP_CYCLES cycles, reqs ignored, then IDLE.
//     Min grant-to-grant spacing = GAP_CYCLES+1 low cycles.
//   - bus_done outside GNTx ignored. Req drop while in GAP/IDLE has no effect.
//   - Re-request by releasing master with other master pending: RR_EN=1 ->
//     other master wins; RR_EN=0 -> m0 wins regardless.
//   - rst mid-tenure: grant drops at that edge, all state as reset; no timeout pulse.
// TESTING
//   1 m0_req=1 alone at cycle 2 -> m0_grant=1,msel=0 at 3; bus_done at 6 ->
//     grant=0 at 7, GAP at 7, IDLE at 8, regrant at 9 if req still high.
//   2 RR_EN=1, m0_req=m1_req=1 from reset, done every 4 cycles -> grants
//     alternate m0,m1,m0,m1; msel follows; never both grants high.
//   3 RR_EN=0, both req continuously -> m1_grant never asserts; m0 re-granted
//     after each GAP.
//   4 TIMEOUT=8, m1 holds req, no bus_done -> m1_grant high exactly 8 cycles,
//     timeout=1 for one cycle on fall; bus_done on cycle 8 instead -> timeout=0.
//   5 GAP_CYCLES=0 and 3: release -> grant-to-grant low time 1 and 4 cycles.
//   6 rst=1 during GNT1 with msel=1 -> next edge m1_grant=0,msel=0,busy=0;
//     after rst, both req -> m0 granted first.

Source files
------------

// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m: two-master bus arbiter with turnaround gap, tenure timeout and mux select
// Round-robin or fixed-priority grant; all outputs registered.
module bus_arbiter_2m #(
  parameter bit RR_EN      = 1'b1,
  parameter int TIMEOUT    = 255,
  parameter int GAP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_req,
  input  logic m1_req,
  input  logic bus_done,
  output logic m0_grant,
  output logic m1_grant,
  output logic msel,
  output logic bus_busy,
  output logic timeout
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic [2:0] r_gap;
  logic r_last, r_msel, r_m0_grant, r_m1_grant, r_busy, r_timeout;
  logic w_in_gnt, w_req, w_to_hit, w_rel, w_pick1;
  always_comb begin
    w_in_gnt = (r_state == GNT0) || (r_state == GNT1);
    w_req    = (r_state == GNT1) ? m1_req : m0_req;
    w_to_hit = (TIMEOUT != 0) && (r_cnt == TO_LAST);
    w_rel    = bus_done || !w_req || w_to_hit;
    // on contention m1 wins only under round-robin when m0 owned the bus last
    w_pick1  = m1_req && (!m0_req || (RR_EN && !r_last));
    w_next   = r_state;
    case (r_state)
      IDLE:       w_next = (m0_req || m1_req) ? (w_pick1 ? GNT1 : GNT0) : IDLE;
      GNT0, GNT1: w_next = w_rel ? ((GAP_CYCLES > 0) ? GAP : IDLE) : r_state;
      default:    w_next = (r_gap == GAP_LAST) ? IDLE : GAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_gap      <= '0;
      r_last     <= 1'b1;
      r_msel     <= 1'b0;
      r_m0_grant <= 1'b0;
      r_m1_grant <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= (w_in_gnt && !w_rel) ? r_cnt + 8'd1 : 8'd0;
      r_gap      <= (r_state == GAP) ? r_gap + 3'd1 : 3'd0;
      if (r_state == IDLE && w_next != IDLE) begin
        r_msel <= (w_next == GNT1);
        r_last <= (w_next == GNT1);
      end
      r_m0_grant <= (w_next == GNT0);
      r_m1_grant <= (w_next == GNT1);
      r_busy     <= (w_next == GNT0) || (w_next == GNT1);
      r_timeout  <= w_in_gnt && w_to_hit && !bus_done && w_req;
    end
  end
  assign m0_grant = r_m0_grant;
  assign m1_grant = r_m1_grant;
  assign msel     = r_msel;
  assign bus_busy = r_busy;
  assign timeout  = r_timeout;
endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb_bus_arbiter_2m: directed checks of three arbiter configurations sharing one stimulus
module tb_bus_arbiter_2m;
  logic clk = 1'b0;
  logic rst, m0, m1, done;
  logic [2:0] g0, g1, ms, bz, to;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  // u0: RR, TIMEOUT 255, gap 1; u1: fixed priority, TIMEOUT 8, gap 3; u2: RR, TIMEOUT 8, gap 0
  bus_arbiter_2m u0 (.clk(clk), .rst(rst), .m0_req(m0), .m1_req(m1), .bus_done(done),
    .m0_grant(g0[0]), .m1_grant(g1[0]), .msel(ms[0]), .bus_busy(bz[0]), .timeout(to[0]));
  bus_arbiter_2m #(.RR_EN(1'b0), .TIMEOUT(8), .GAP_CYCLES(3)) u1 (.clk(clk), .rst(rst),
    .m0_req(m0), .m1_req(m1), .bus_done(done), .m0_grant(g0[1]), .m1_grant(g1[1]),
    .msel(ms[1]), .bus_busy(bz[1]), .timeout(to[1]));
  bus_arbiter_2m #(.RR_EN(1'b1), .TIMEOUT(8), .GAP_CYCLES(0)) u2 (.clk(clk), .rst(rst),
    .m0_req(m0), .m1_req(m1), .bus_done(done), .m0_grant(g0[2]), .m1_grant(g1[2]),
    .msel(ms[2]), .bus_busy(bz[2]), .timeout(to[2]));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] st(input int i);
    return {3'b0, g0[i], g1[i], ms[i], bz[i], to[i]};
  endfunction
  initial begin
    rst = 1'b1; m0 = 1'b0; m1 = 1'b0; done = 1'b0;
    step(); step();
    chk("reset_u0", st(0), 8'h00);
    chk("reset_u1", st(1), 8'h00);
    rst = 1'b0;
    // single m0 request, released by bus_done, then re-granted after the gap
    m0 = 1'b1;
    step(); chk("t1_grant", st(0), 8'b10010);
    step(); step();
    done = 1'b1;
    step(); done = 1'b0;
    chk("t1_release", st(0), 8'h00);
    step(); chk("t1_gap_idle", st(0), 8'h00);
    step(); chk("t1_regrant", st(0), 8'b10010);
    m0 = 1'b0;
    step(); chk("t1_reqdrop", st(0), 8'h00);
    // round-robin alternation from reset
    rst = 1'b1; step(); rst = 1'b0;
    m0 = 1'b1; m1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(); chk("t2_owner", st(0), (k % 2) ? 8'b01110 : 8'b10010);
      step();
      done = 1'b1;
      step(); done = 1'b0;
      chk("t2_release", {g0[0], g1[0]}, 8'h0);
      step(); chk("t2_gap", {g0[0], g1[0]}, 8'h0);
    end
    // fixed priority: m1 starved, m0 times out after exactly 8 cycles, 4 low cycles with gap 3
    rst = 1'b1; step(); rst = 1'b0;
    for (int it = 0; it < 2; it++) begin
      step(); chk("t3_grant_m0", st(1), 8'b10010);
      for (int c = 0; c < 7; c++) begin
        step(); chk("t4_tenure", {g0[1], g1[1], to[1]}, 8'b100);
      end
      done = (it == 1);
      step(); done = 1'b0;
      chk("t4_release_to", {g0[1], g1[1], bz[1], to[1]}, (it == 1) ? 8'b0000 : 8'b0001);
      for (int c = 0; c < 3; c++) begin
        step(); chk("t5_gap3_low", {g0[1], g1[1], to[1]}, 8'b000);
      end
    end
    step(); chk("t3_regrant_m0", {g0[1], g1[1]}, 8'b10);
    // m1 alone on u2: 8-cycle timeout then re-grant after a single low cycle
    rst = 1'b1; step(); rst = 1'b0;
    m0 = 1'b0; m1 = 1'b1;
    step(); chk("t4_m1_grant", st(2), 8'b01110);
    for (int c = 0; c < 7; c++) begin
      step(); chk("t4_m1_tenure", {g1[2], to[2]}, 8'b10);
    end
    step(); chk("t4_m1_timeout", st(2), 8'b00101);
    step(); chk("t5_gap0_regrant", st(2), 8'b01110);
    // reset mid-tenure with msel=1, then contention goes to m0
    step();
    rst = 1'b1; m0 = 1'b1;
    step(); chk("t6_rst_u2", st(2), 8'h00);
    rst = 1'b0;
    step(); chk("t6_first_m0", st(2), 8'b10010);
    m0 = 1'b0; m1 = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
